// File: rtl/mme_accum_wb.sv
// Writeback of an SA_WIDTH x SA_WIDTH accumulator tile to memory, one AXI INCR burst per row.
// Elements are saturated to DW bits at capture; only one burst is outstanding at a time.
module mme_accum_wb #(
   parameter int unsigned DW       = 32,
   parameter int unsigned SA_WIDTH = 4,
   parameter int unsigned AW       = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [AW-1:0]        base_addr_i,
   input  logic [AW-1:0]        row_stride_i,
   input  logic signed [2*DW:0] accum_i [SA_WIDTH][SA_WIDTH],
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 awvalid_o,
   input  logic                 awready_i,
   output logic [AW-1:0]        awaddr_o,
   output logic [3:0]           awlen_o,
   output logic [2:0]           awsize_o,
   output logic [1:0]           awburst_o,
   output logic [3:0]           awid_o,
   output logic                 wvalid_o,
   input  logic                 wready_i,
   output logic [DW-1:0]        wdata_o,
   output logic [DW/8-1:0]      wstrb_o,
   output logic                 wlast_o,
   output logic [3:0]           wid_o,
   input  logic                 bvalid_i,
   output logic                 bready_o,
   input  logic [1:0]           bresp_i,
   input  logic [3:0]           bid_i
);

   localparam int unsigned IW = (SA_WIDTH > 1) ? $clog2(SA_WIDTH) : 1;
   localparam logic [IW-1:0] Last = IW'(SA_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StAw, StW, StB, StDone} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   row_q, row_d;
   logic [IW-1:0]   k_q, k_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW-1:0]   stride_q, stride_d;
   logic            err_q, err_d;
   logic            capture;
   logic [DW-1:0]   data_q [SA_WIDTH][SA_WIDTH];
   logic            unused_bid;

   assign unused_bid = ^bid_i;

   // Fits in DW bits when the top DW+2 bits are all copies of the sign.
   function automatic logic [DW-1:0] sat(input logic signed [2*DW:0] v);
      if ((&v[2*DW:DW-1]) || !(|v[2*DW:DW-1])) begin
         return v[DW-1:0];
      end else if (v[2*DW]) begin
         return {1'b1, {(DW-1){1'b0}}};
      end else begin
         return {1'b0, {(DW-1){1'b1}}};
      end
   endfunction

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      k_d      = k_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      err_d    = err_q;
      capture  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               capture  = 1'b1;
               row_d    = '0;
               k_d      = '0;
               addr_d   = base_addr_i;
               stride_d = row_stride_i;
               err_d    = 1'b0;
               state_d  = StAw;
            end
         end
         StAw: begin
            if (awready_i) begin
               k_d     = '0;
               state_d = StW;
            end
         end
         StW: begin
            if (wready_i) begin
               if (k_q == Last) begin
                  state_d = StB;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         StB: begin
            if (bvalid_i) begin
               if (bresp_i != 2'b00) begin
                  err_d = 1'b1;
               end
               if (row_q == Last) begin
                  state_d = StDone;
               end else begin
                  row_d   = row_q + 1'b1;
                  addr_d  = addr_q + stride_q;
                  state_d = StAw;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         row_q    <= '0;
         k_q      <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         k_q      <= k_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(SA_WIDTH); r++) begin
            for (int c = 0; c < int'(SA_WIDTH); c++) begin
               data_q[r][c] <= '0;
            end
         end
      end else if (capture) begin
         for (int r = 0; r < int'(SA_WIDTH); r++) begin
            for (int c = 0; c < int'(SA_WIDTH); c++) begin
               data_q[r][c] <= sat(accum_i[r][c]);
            end
         end
      end
   end

   // All handshake outputs decode from registered state only.
   assign awvalid_o = (state_q == StAw);
   assign wvalid_o  = (state_q == StW);
   assign bready_o  = (state_q == StB);
   assign done_o    = (state_q == StDone);
   assign busy_o    = (state_q == StAw) || (state_q == StW) || (state_q == StB);
   assign err_o     = err_q;

   assign awaddr_o  = addr_q;
   assign awlen_o   = 4'(SA_WIDTH - 1);
   assign awsize_o  = 3'($clog2(DW / 8));
   assign awburst_o = 2'b01;
   assign awid_o    = 4'd0;

   assign wdata_o   = data_q[row_q][k_q];
   assign wstrb_o   = '1;
   assign wlast_o   = (state_q == StW) && (k_q == Last);
   assign wid_o     = 4'd0;

endmodule

// File: doc/mme_accum_wb.md
MME_ACCUM_WB -- requirements
Module: mme_accum_wb

Interface
REQ-001 SHALL have parameter DW, default 32, output element width in bits.
REQ-002 SHALL have parameter SA_WIDTH, default 4, accumulator array side in PEs, which is also the beats per row burst.
REQ-003 SHALL have parameter AW, default 32, AXI address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1, one-cycle writeback request.
REQ-007 SHALL have port base_addr_i, input, AW, byte address of C[0][0].
REQ-008 SHALL have port row_stride_i, input, AW, byte distance between consecutive C rows.
REQ-009 SHALL have port accum_i, input, SA_WIDTH x SA_WIDTH x (2*DW+1) signed, the MM engine result array [row][col].
REQ-010 SHALL have port busy_o, input-independent output, 1, high from the capture cycle until done_o.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err_o, output, 1, sticky flag for any non-OKAY bresp; cleared on start.
REQ-013 SHALL have ports awvalid_o/awready_i, awaddr_o[AW], awlen_o[4], awsize_o[3], awburst_o[2], awid_o[4]: AXI write-address channel.
REQ-014 SHALL have ports wvalid_o/wready_i, wdata_o[DW], wstrb_o[DW/8], wlast_o, wid_o[4]: AXI write-data channel.
REQ-015 SHALL have ports bvalid_i/bready_o, bresp_i[2], bid_i[4]: AXI write-response channel.

Function
REQ-016 SHALL implement states IDLE, AW, W, B and DONE.
REQ-017 SHALL, in IDLE with start_i=1, register accum_i into a SA_WIDTH x SA_WIDTH DW-bit array, capture base_addr_i and row_stride_i, set row=0, clear err_o, and go to AW.
REQ-018 SHALL saturate each element on capture: values above 2^(DW-1)-1 become 0x7FFFFFFF, values below -2^(DW-1) become 0x80000000, and all other values take the low DW bits.
REQ-019 SHALL ignore start_i when not in IDLE, with no effect on the captured data or the state.
REQ-020 SHALL, in AW, assert awvalid_o with awaddr=base+row*stride (mod 2^AW), awlen=SA_WIDTH-1, awsize=log2(DW/8), awburst=INCR(01) and awid=0.
REQ-021 SHALL hold awvalid_o and the AW payload stable until awready_i, then go to W on the handshake cycle.
REQ-022 SHALL, in W, present beat k=0..SA_WIDTH-1 as wdata=C[row][k], wstrb all ones, wid=0, with wlast=1 only on k=SA_WIDTH-1.
REQ-023 SHALL advance k only on wvalid_o&wready_i, and SHALL hold the beat payload stable while it is stalled.
REQ-024 SHALL go from W to B after the handshake of the last beat.
REQ-025 SHALL NOT assert wvalid_o before the AW handshake of the same row.
REQ-026 SHALL, in B, assert bready_o and wait for bvalid_i; on the handshake, set err_o if bresp_i!=00.
REQ-027 SHALL, on the B handshake, go to AW with row+1 if row<SA_WIDTH-1, otherwise go to DONE.
REQ-028 SHALL, in DONE, assert done_o for exactly one cycle, deassert busy_o in the same cycle, and return to IDLE.
REQ-029 SHALL keep at most one outstanding burst at any time; the next AW is issued only after the previous B.
REQ-030 SHALL produce a minimum total latency, with all readies tied high, of SA_WIDTH*(1+SA_WIDTH+1)+1 cycles from the start cycle to done_o, which is 25 for SA_WIDTH=4.
REQ-031 SHALL handle a bvalid_i that arrives while in AW or W by keeping bready_o low and ignoring it.
REQ-032 SHALL not check bid_i.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state=IDLE and drive awvalid_o, wvalid_o, wlast_o, bready_o, busy_o, done_o and err_o to 0.
REQ-034 SHALL reset row, k, the address registers and the data array to 0.
REQ-035 SHALL abandon any burst in progress on reset mid-operation, without completing it or pulsing done_o.

Verification
REQ-036 SHALL cover the basic case: base=0x1000, stride=0x10, accum[r][c]=r*4+c, all readies high -> AW addresses 0x1000, 0x1010, 0x1020, 0x1030; data 0..15 in order; wlast on beats 3, 7, 11, 15; done at cycle 25.
REQ-037 SHALL cover saturation: accum[0][0]=2^40, accum[0][1]=-2^40, accum[0][2]=-5 -> wdata 0x7FFFFFFF, 0x80000000, 0xFFFFFFFB.
REQ-038 SHALL cover backpressure: random awready/wready stalls of 0-5 cycles -> payload stable during stalls; same data and order as the basic case; done_o exactly once.
REQ-039 SHALL cover the error response: bresp=10 on row 1 -> err_o=1 from that cycle through done_o; the next start clears it.
REQ-040 SHALL cover start while busy plus address wrap: start pulsed during W -> ignored; base=0xFFFFFFF0 with stride 0x10 -> row 1 awaddr=0x00000000.
REQ-041 SHALL cover reset mid-burst: rst_n low during W beat 2 -> all valids and busy_o 0 in that cycle; no done_o; a new start then runs cleanly.
